relu_grad_unit: RTL and testbench
=================================

Name: relu_grad_unit

Overview:
Backward-pass counterpart to the forward ReLU array, used for on-chip training.
- Forward side: while pre-activation tile rows stream past, captures the ReLU derivative mask, one bit per element (1 when the value is strictly positive).
- Backward side: later accepts gradient rows for the same tile and emits each gradient element unchanged where its mask bit is 1, and zeroed where it is 0.
- Masks are buffered per tile in a small FIFO, so forward and backward traffic may overlap.

Parameters:
- SIZE, 8, tile dimension: elements per row and rows per tile.
- DATA_W, 32, element width, signed two's complement.
- DEPTH, 2, number of tile masks buffered; must be at least 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- fwd_valid  in  1  forward row valid.
- fwd_ready  out  1  forward row accepted this cycle when fwd_valid is also high.
- fwd_row  in  [SIZE-1:0][DATA_W-1:0]  pre-activation row.
- grad_valid  in  1  gradient row valid.
- grad_ready  out  1  gradient row accepted when grad_valid is also high.
- grad_row  in  [SIZE-1:0][DATA_W-1:0]  upstream gradient row.
- out_valid  out  1  masked gradient row valid.
- out_ready  in  1  downstream accepts the output row.
- out_row  out  [SIZE-1:0][DATA_W-1:0]  masked gradient row.
- out_last  out  1  out_row is row SIZE-1 of its tile.
- mask_count  out  $clog2(DEPTH+1)  number of complete tile masks buffered.

Behaviour:
- Reset (async assert, sync release): all of the following clear to 0:
  - out_valid, out_row, out_last, mask_count
  - forward and backward row counters, write and read pointers
  - mask storage
  - After reset, fwd_ready=1 and grad_ready=0.
- Mask bit for element j: 1 iff fwd_row[j] is signed-greater than 0. Zero and negative values give 0.
- Forward path:
  - fwd_ready = (mask_count < DEPTH).
  - On fwd_valid && fwd_ready:
    - Write the SIZE mask bits into slot wr_ptr, row fwd_row_cnt.
    - Increment fwd_row_cnt.
  - At row SIZE-1:
    - fwd_row_cnt wraps to 0.
    - wr_ptr advances, modulo DEPTH.
    - The tile is committed: mask_count increments.
  - A partially written tile is not visible to the backward side.
- Backward path:
  - grad_ready = (mask_count > 0) && (!out_valid || out_ready).
  - On grad_valid && grad_ready, the next cycle has:
    - out_valid=1.
    - out_row[j] = mask[rd_ptr][bwd_row_cnt][j] ? grad_row[j] : 0.
    - out_last = (bwd_row_cnt == SIZE-1).
  - Latency is 1 cycle from acceptance to out_valid.
  - Increment bwd_row_cnt. At SIZE-1 it wraps to 0, rd_ptr advances modulo DEPTH, and the tile is released: mask_count decrements.
- Output handshake:
  - out_valid && !out_ready: out_row and out_last hold stable.
  - out_valid && out_ready with no new accept: out_valid drops to 0.
  - Accept and drain in the same cycle: full throughput, one row per cycle.
- Simultaneous commit and release in one cycle: mask_count is unchanged; both pointers advance.
- When mask_count == DEPTH, the forward side stalls with fwd_ready=0 until a release.
  - The release cycle itself still reports fwd_ready=0; ready is registered off mask_count.
- Reset mid-tile discards partial tiles and all buffered masks; no output row is produced afterward.
- Arithmetic: no width growth. Masked elements pass bit-exact or are forced to all zeros.

Decomposition:
- Shared package relu_pkg holds:
  - typedef data_t, logic signed [DATA_W-1:0]
  - typedef row_t, data_t [SIZE-1:0]
  - typedef mask_row_t, logic [SIZE-1:0]
  - constants TILE_SIZE=8 and DATA_WIDTH=32, shared with the forward ReLU array.
- Sub-module relu_mask_buffer: DEPTH×SIZE×SIZE bit storage with wr/rd pointers, row counters and mask_count.
- The top level adds the mask compare, the gating and the output register.

Test Plan:
- Reset then a single tile:
  - Stimulus: forward row 0 = {5, -3, 0, 1, -1, 7, 0x7FFFFFFF, 0x80000000}, rows 1-7 all 1.
  - Gradients all 0x10; out_ready held high.
  - Required: output row 0 = {0x10, 0, 0, 0x10, 0, 0x10, 0x10, 0}, rows 1-7 all 0x10.
  - Required: out_last only on the 8th row; mask_count goes 0→1→0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 3 cycles with out_valid=1.
  - Required: out_row stable and grad_ready=0 throughout.
  - Required: once out_ready rises, the next row follows with no gap.
- FIFO full (DEPTH=2):
  - Stimulus: stream 3 forward tiles with no gradients.
  - Required: fwd_ready drops after the 16th row and mask_count=2.
  - Required: after 8 gradient rows, mask_count=1 and fwd_ready=1 again.
- Overlap:
  - Stimulus: commit tile B's last forward row in the same cycle as tile A's last gradient row.
  - Required: mask_count unchanged; tile B gradients are masked with B's mask.
- Gradient before mask:
  - Stimulus: grad_valid=1 with only 5 forward rows of the first tile written.
  - Required: grad_ready=0 until the 8th forward row commits.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 after 3 backward rows.
  - Required: out_valid=0 and mask_count=0 immediately (asynchronous).
  - Required: the next tile's masks start at row 0.

Source files
------------

// File: rtl/relu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : relu_pkg
//  Description : Types and constants shared by the forward ReLU array and
//                the ReLU gradient unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package relu_pkg;

  localparam int TILE_SIZE  = 8;
  localparam int DATA_WIDTH = 32;

  typedef logic signed [DATA_WIDTH-1:0] data_t;
  typedef data_t [TILE_SIZE-1:0]        row_t;
  typedef logic [TILE_SIZE-1:0]         mask_row_t;

endpackage : relu_pkg
`default_nettype wire

// File: rtl/relu_mask_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : relu_mask_buffer
//  Description : DEPTH-tile FIFO of ReLU derivative masks. Forward rows are
//                written row by row into the tile at the write pointer; a
//                tile becomes readable only once its last row is written.
//  Revision    : 1.0 - initial release
// ============================================================================
module relu_mask_buffer
  import relu_pkg::*;
#(
  parameter int SIZE  = TILE_SIZE,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [SIZE-1:0]  wr_mask,
  input  logic             rd_en,
  output logic [SIZE-1:0]  rd_mask,
  output logic             rd_last,
  output logic [CNT_W-1:0] mask_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ROW_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  localparam logic [ROW_W-1:0] C_LAST_ROW = ROW_W'(SIZE - 1);
  localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(DEPTH - 1);

  logic [SIZE-1:0]  r_mask [DEPTH][SIZE];
  logic [ROW_W-1:0] r_fwd_row;
  logic [ROW_W-1:0] r_bwd_row;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_commit;
  logic w_release;

  function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
    return (p == C_LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign w_commit   = wr_en && (r_fwd_row == C_LAST_ROW);
  assign w_release  = rd_en && (r_bwd_row == C_LAST_ROW);

  assign rd_mask    = r_mask[r_rd_ptr][r_bwd_row];
  assign rd_last    = (r_bwd_row == C_LAST_ROW);
  assign mask_count = r_count;

  // Mask storage: one row of bits written per accepted forward row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < DEPTH; t++) begin
        for (int r = 0; r < SIZE; r++) begin
          r_mask[t][r] <= '0;
        end
      end
    end else if (wr_en) begin
      r_mask[r_wr_ptr][r_fwd_row] <= wr_mask;
    end
  end

  // Forward row counter and write pointer; the pointer moves on tile commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_row <= '0;
      r_wr_ptr  <= '0;
    end else if (wr_en) begin
      r_fwd_row <= w_commit ? '0 : r_fwd_row + 1'b1;
      if (w_commit) begin
        r_wr_ptr <= f_next_ptr(r_wr_ptr);
      end
    end
  end

  // Backward row counter and read pointer; the pointer moves on tile release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bwd_row <= '0;
      r_rd_ptr  <= '0;
    end else if (rd_en) begin
      r_bwd_row <= w_release ? '0 : r_bwd_row + 1'b1;
      if (w_release) begin
        r_rd_ptr <= f_next_ptr(r_rd_ptr);
      end
    end
  end

  // Committed-tile count; a commit and a release in the same cycle cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_commit, w_release})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : relu_mask_buffer
`default_nettype wire

// File: rtl/relu_grad_unit.sv
`default_nettype none
// ============================================================================
//  Module      : relu_grad_unit
//  Description : Backward-pass ReLU. Captures the derivative mask of each
//                forward tile and applies it to the matching gradient rows,
//                passing gradients where the pre-activation was positive.
//  Revision    : 1.0 - initial release
// ============================================================================
module relu_grad_unit
  import relu_pkg::*;
#(
  parameter int SIZE   = TILE_SIZE,
  parameter int DATA_W = DATA_WIDTH,
  parameter int DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fwd_valid,
  output logic                          fwd_ready,
  input  logic [SIZE-1:0][DATA_W-1:0]   fwd_row,
  input  logic                          grad_valid,
  output logic                          grad_ready,
  input  logic [SIZE-1:0][DATA_W-1:0]   grad_row,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SIZE-1:0][DATA_W-1:0]   out_row,
  output logic                          out_last,
  output logic [$clog2(DEPTH+1)-1:0]    mask_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                        w_fwd_fire;
  logic                        w_grad_fire;
  logic [SIZE-1:0]             w_fwd_mask;
  logic [SIZE-1:0]             w_rd_mask;
  logic                        w_rd_last;
  logic [SIZE-1:0][DATA_W-1:0] w_gated;

  logic                        r_out_valid;
  logic [SIZE-1:0][DATA_W-1:0] r_out_row;
  logic                        r_out_last;

  // Forward side stalls only when every tile slot holds a committed mask.
  assign fwd_ready   = (mask_count < CNT_W'(DEPTH));
  assign grad_ready  = (mask_count != '0) && (!r_out_valid || out_ready);
  assign w_fwd_fire  = fwd_valid && fwd_ready;
  assign w_grad_fire = grad_valid && grad_ready;

  generate
    for (genvar j = 0; j < SIZE; j++) begin : g_lane
      // Strictly positive: sign bit clear and not all zeros.
      assign w_fwd_mask[j] = !fwd_row[j][DATA_W-1] && (|fwd_row[j]);
      assign w_gated[j]    = w_rd_mask[j] ? grad_row[j] : '0;
    end
  endgenerate

  relu_mask_buffer #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_mask_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (w_fwd_fire),
    .wr_mask    (w_fwd_mask),
    .rd_en      (w_grad_fire),
    .rd_mask    (w_rd_mask),
    .rd_last    (w_rd_last),
    .mask_count (mask_count)
  );

  // Output register: load on accept, hold under backpressure, clear on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
      r_out_last  <= 1'b0;
    end else if (w_grad_fire) begin
      r_out_valid <= 1'b1;
      r_out_row   <= w_gated;
      r_out_last  <= w_rd_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_row   = r_out_row;
  assign out_last  = r_out_last;

endmodule : relu_grad_unit
`default_nettype wire

// File: tb/tb_relu_grad_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_relu_grad_unit
//  Description : Self-checking bench for relu_grad_unit against a tile-level
//                reference model (queue of forward rows, committed-tile count).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_relu_grad_unit;
  import relu_pkg::*;

  localparam int SIZE   = TILE_SIZE;
  localparam int DATA_W = DATA_WIDTH;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef logic [SIZE-1:0][DATA_W-1:0] prow_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             fwd_valid = 1'b0;
  logic             fwd_ready;
  prow_t            fwd_row = '0;
  logic             grad_valid = 1'b0;
  logic             grad_ready;
  prow_t            grad_row = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  prow_t            out_row;
  logic             out_last;
  logic [CNT_W-1:0] mask_count;

  always #5 clk = ~clk;

  relu_grad_unit #(.SIZE(SIZE), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fwd_valid  (fwd_valid),
    .fwd_ready  (fwd_ready),
    .fwd_row    (fwd_row),
    .grad_valid (grad_valid),
    .grad_ready (grad_ready),
    .grad_row   (grad_row),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .out_last   (out_last),
    .mask_count (mask_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: forward rows not yet consumed, position in each tile,
  // number of complete tiles, and the expected output register.
  prow_t m_rows[$];
  int    m_fcnt;
  int    m_bcnt;
  int    m_tiles;
  logic  m_ov;
  logic  m_ol;
  prow_t m_orow;

  task automatic model_reset();
    m_rows.delete();
    m_fcnt  = 0;
    m_bcnt  = 0;
    m_tiles = 0;
    m_ov    = 1'b0;
    m_ol    = 1'b0;
    m_orow  = '0;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic prow_t rand_row();
    prow_t r;
    for (int j = 0; j < SIZE; j++) begin
      case ($urandom_range(0, 3))
        0:       r[j] = '0;
        1:       r[j] = 32'($urandom);
        2:       r[j] = -32'($urandom_range(1, 1000));
        default: r[j] = 32'($urandom_range(1, 1000));
      endcase
    end
    return r;
  endfunction

  function automatic prow_t expect_row(input prow_t f, input prow_t g);
    prow_t e;
    for (int j = 0; j < SIZE; j++) begin
      e[j] = ($signed(f[j]) > 0) ? g[j] : '0;
    end
    return e;
  endfunction

  // One clock cycle: drive at posedge+1, check readies, update the model,
  // then check registered outputs at the next posedge+1.
  task automatic cycle(input logic fv, input prow_t fr, input logic gv,
                       input prow_t gr, input logic orr);
    logic  exp_fr;
    logic  exp_gr;
    prow_t f;
    fwd_valid  = fv;
    fwd_row    = fr;
    grad_valid = gv;
    grad_row   = gr;
    out_ready  = orr;
    #1;
    exp_fr = (m_tiles < DEPTH);
    exp_gr = (m_tiles > 0) && (!m_ov || orr);
    chk("fwd_ready", 256'(fwd_ready), 256'(exp_fr));
    chk("grad_ready", 256'(grad_ready), 256'(exp_gr));
    if (gv && exp_gr) begin
      f      = m_rows.pop_front();
      m_orow = expect_row(f, gr);
      m_ol   = (m_bcnt == SIZE - 1);
      m_ov   = 1'b1;
      m_bcnt = (m_bcnt + 1) % SIZE;
      if (m_bcnt == 0) m_tiles--;
    end else if (m_ov && orr) begin
      m_ov = 1'b0;
    end
    if (fv && exp_fr) begin
      m_rows.push_back(fr);
      m_fcnt = (m_fcnt + 1) % SIZE;
      if (m_fcnt == 0) m_tiles++;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 256'(out_valid), 256'(m_ov));
    chk("mask_count", 256'(mask_count), 256'(m_tiles));
    if (m_ov) begin
      chk("out_row", 256'(out_row), 256'(m_orow));
      chk("out_last", 256'(out_last), 256'(m_ol));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic fwd_tile();
    for (int i = 0; i < SIZE; i++) cycle(1'b1, rand_row(), 1'b0, '0, 1'b1);
  endtask

  task automatic grad_rows(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, rand_row(), 1'b1);
  endtask

  initial begin
    prow_t r0;
    prow_t ones;
    prow_t g10;
    prow_t exp0;
    prow_t held;

    model_reset();

    // Reset values, observed while reset is asserted.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_row", 256'(out_row), 256'(0));
    chk("rst_out_last", 256'(out_last), 256'(0));
    chk("rst_mask_count", 256'(mask_count), 256'(0));
    chk("rst_fwd_ready", 256'(fwd_ready), 256'(1));
    chk("rst_grad_ready", 256'(grad_ready), 256'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single directed tile; gradients offered before the mask is complete.
    r0[0] = 32'd5;  r0[1] = -32'd3; r0[2] = 32'd0;          r0[3] = 32'd1;
    r0[4] = -32'd1; r0[5] = 32'd7;  r0[6] = 32'h7FFF_FFFF;  r0[7] = 32'h8000_0000;
    for (int j = 0; j < SIZE; j++) begin
      ones[j] = 32'd1;
      g10[j]  = 32'h10;
    end
    exp0[0] = 32'h10; exp0[1] = '0; exp0[2] = '0;     exp0[3] = 32'h10;
    exp0[4] = '0;     exp0[5] = 32'h10; exp0[6] = 32'h10; exp0[7] = '0;
    cycle(1'b1, r0, 1'b1, g10, 1'b1);
    for (int i = 1; i < SIZE; i++) cycle(1'b1, ones, 1'b1, g10, 1'b1);
    chk("tile1_committed", 256'(mask_count), 256'(1));
    cycle(1'b0, '0, 1'b1, g10, 1'b1);
    chk("tile1_row0", 256'(out_row), 256'(exp0));
    for (int i = 1; i < SIZE; i++) cycle(1'b0, '0, 1'b1, g10, 1'b1);
    chk("tile1_last", 256'(out_last), 256'(1));
    chk("tile1_released", 256'(mask_count), 256'(0));
    idle(2);

    // Backpressure: three stalled cycles, then back-to-back rows.
    fwd_tile();
    grad_rows(1);
    held = out_row;
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, rand_row(), 1'b0);
    chk("bp_row_stable", 256'(out_row), 256'(held));
    grad_rows(SIZE - 1);
    idle(2);

    // FIFO full: three forward tiles offered, only two fit.
    for (int i = 0; i < 3 * SIZE; i++) cycle(1'b1, rand_row(), 1'b0, '0, 1'b1);
    chk("full_count", 256'(mask_count), 256'(2));
    chk("full_fwd_ready", 256'(fwd_ready), 256'(0));
    grad_rows(SIZE);
    chk("after_release_count", 256'(mask_count), 256'(1));
    chk("after_release_fwd_ready", 256'(fwd_ready), 256'(1));
    grad_rows(SIZE);
    idle(2);

    // Overlap: tile B commits in the same cycle tile A is released.
    fwd_tile();
    for (int i = 0; i < SIZE; i++) cycle(1'b1, rand_row(), 1'b1, rand_row(), 1'b1);
    chk("overlap_count", 256'(mask_count), 256'(1));
    grad_rows(SIZE);
    idle(2);

    // Randomized mixed traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), rand_row(), 1'($urandom_range(0, 1)),
            rand_row(), 1'($urandom_range(0, 3) != 0));
    end

    // Reset in the middle of a tile's backward pass.
    for (int i = 0; i < 2 * SIZE && m_tiles == 0; i++) begin
      cycle(1'b1, rand_row(), 1'b0, '0, 1'b1);
    end
    grad_rows(3);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 256'(out_valid), 256'(0));
    chk("midrst_mask_count", 256'(mask_count), 256'(0));
    chk("midrst_grad_ready", 256'(grad_ready), 256'(0));
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    fwd_tile();
    grad_rows(SIZE);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_relu_grad_unit
`default_nettype wire
